// File: rtl/rtc_bus_sequencer.sv
// Bus sequencer for the external RTC chip: turns controller command levels into
// fixed sequences of multiplexed address/data read or write cycles.
module rtc_bus_sequencer #(
  parameter int unsigned T_PHASE = 4,       // cycles per bus phase, 2..15
  parameter logic [7:0]  REG_CTL = 8'h02,   // control/status register
  parameter logic [7:0]  REG_SEG = 8'h21    // seconds; minutes and hours follow
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       whileT,
  input  logic       CrontUs,
  input  logic [7:0] usr_seg,
  input  logic [7:0] usr_min,
  input  logic [7:0] usr_hora,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       AD_sel,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       finint,
  output logic       finwt,
  output logic       finct,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic       busy
);

  localparam logic [3:0] PhaseLast = 4'(T_PHASE - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StGap1, StData, StGap2, StDone} state_e;
  typedef enum logic [1:0] {ModeInit, ModeRead, ModeWrite} mode_e;

  state_e     state_q;
  mode_e      mode_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;

  logic       ini_q, wt_q, ct_q;
  logic       ini_rise, wt_rise, ct_rise;

  logic [7:0] useg_q, umin_q, uhora_q;
  logic [7:0] sh0_q, sh1_q, sh2_q;

  logic [7:0] ad_out_q;
  logic       ad_oe_q, ad_sel_q, cs_n_q, rd_n_q, wr_n_q;
  logic       finint_q, finwt_q, finct_q, busy_q;
  logic [7:0] seg_q, min_q, hora_q;

  logic       cnt_last;

  assign ini_rise = iniciar & ~ini_q;
  assign wt_rise  = whileT & ~wt_q;
  assign ct_rise  = CrontUs & ~ct_q;
  assign cnt_last = (cnt_q == PhaseLast);

  // Address of entry i within the sequence of mode m.
  function automatic logic [7:0] entry_addr(input mode_e m, input logic [1:0] i);
    if (m == ModeInit) begin
      return REG_CTL;
    end
    return REG_SEG + {6'b0, i};
  endfunction

  // Write data of entry i; user values come from the copy taken at acceptance.
  function automatic logic [7:0] entry_data(input mode_e m, input logic [1:0] i);
    logic [7:0] d;
    d = 8'h00;
    if (m == ModeInit) begin
      d = (i == 2'd0) ? 8'h10 : 8'h00;
    end else if (m == ModeWrite) begin
      case (i)
        2'd0:    d = useg_q;
        2'd1:    d = umin_q;
        default: d = uhora_q;
      endcase
    end
    return d;
  endfunction

  function automatic logic [1:0] last_idx(input mode_e m);
    return (m == ModeInit) ? 2'd1 : 2'd2;
  endfunction

  // Previous command levels for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ini_q <= 1'b0;
      wt_q  <= 1'b0;
      ct_q  <= 1'b0;
    end else begin
      ini_q <= iniciar;
      wt_q  <= whileT;
      ct_q  <= CrontUs;
    end
  end

  // Sequencer FSM; every bus output is registered alongside the state it belongs to.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= StIdle;
      mode_q   <= ModeInit;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      useg_q   <= 8'h00;
      umin_q   <= 8'h00;
      uhora_q  <= 8'h00;
      sh0_q    <= 8'h00;
      sh1_q    <= 8'h00;
      sh2_q    <= 8'h00;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      finint_q <= 1'b0;
      finwt_q  <= 1'b0;
      finct_q  <= 1'b0;
      busy_q   <= 1'b0;
      seg_q    <= 8'h00;
      min_q    <= 8'h00;
      hora_q   <= 8'h00;
    end else begin
      finint_q <= 1'b0;
      finwt_q  <= 1'b0;
      finct_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (ini_rise || ct_rise || wt_rise) begin
            state_q  <= StAddr;
            cnt_q    <= 4'd0;
            idx_q    <= 2'd0;
            busy_q   <= 1'b1;
            cs_n_q   <= 1'b0;
            wr_n_q   <= 1'b0;
            rd_n_q   <= 1'b1;
            ad_sel_q <= 1'b0;
            ad_oe_q  <= 1'b1;
            // Priority: init, then user write, then periodic read.
            if (ini_rise) begin
              mode_q   <= ModeInit;
              ad_out_q <= entry_addr(ModeInit, 2'd0);
            end else if (ct_rise) begin
              mode_q   <= ModeWrite;
              useg_q   <= usr_seg;
              umin_q   <= usr_min;
              uhora_q  <= usr_hora;
              ad_out_q <= entry_addr(ModeWrite, 2'd0);
            end else begin
              mode_q   <= ModeRead;
              ad_out_q <= entry_addr(ModeRead, 2'd0);
            end
          end
        end
        StAddr: begin
          if (cnt_last) begin
            state_q <= StGap1;
            cnt_q   <= 4'd0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StGap1: begin
          if (cnt_last) begin
            state_q  <= StData;
            cnt_q    <= 4'd0;
            cs_n_q   <= 1'b0;
            ad_sel_q <= 1'b1;
            if (mode_q == ModeRead) begin
              rd_n_q  <= 1'b0;
              ad_oe_q <= 1'b0;
            end else begin
              wr_n_q   <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= entry_data(mode_q, idx_q);
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StData: begin
          if (cnt_last) begin
            state_q <= StGap2;
            cnt_q   <= 4'd0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            // Read data is taken on the last cycle the strobe is low.
            if (mode_q == ModeRead) begin
              case (idx_q)
                2'd0:    sh0_q <= ad_in;
                2'd1:    sh1_q <= ad_in;
                default: sh2_q <= ad_in;
              endcase
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StGap2: begin
          if (cnt_last) begin
            cnt_q <= 4'd0;
            if (idx_q == last_idx(mode_q)) begin
              state_q <= StDone;
              case (mode_q)
                ModeInit:  finint_q <= 1'b1;
                ModeWrite: finct_q  <= 1'b1;
                default: begin
                  // Publish all three together so the display never sees a mix.
                  finwt_q <= 1'b1;
                  seg_q   <= sh0_q;
                  min_q   <= sh1_q;
                  hora_q  <= sh2_q;
                end
              endcase
            end else begin
              state_q  <= StAddr;
              idx_q    <= idx_q + 2'd1;
              cs_n_q   <= 1'b0;
              wr_n_q   <= 1'b0;
              ad_sel_q <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= entry_addr(mode_q, idx_q + 2'd1);
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign AD_sel = ad_sel_q;
  assign CS_n   = cs_n_q;
  assign RD_n   = rd_n_q;
  assign WR_n   = wr_n_q;
  assign finint = finint_q;
  assign finwt  = finwt_q;
  assign finct  = finct_q;
  assign seg    = seg_q;
  assign min    = min_q;
  assign hora   = hora_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with a small RTC chip model on the AD bus.
module tb_rtc_bus_sequencer;

  logic       CLK;
  logic       reset;
  logic       iniciar, whileT, CrontUs;
  logic [7:0] usr_seg, usr_min, usr_hora;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, AD_sel, CS_n, RD_n, WR_n;
  logic       finint, finwt, finct, busy;
  logic [7:0] seg, min, hora;

  int checks = 0;
  int errors = 0;

  // RTC chip model state
  logic [7:0]  rtc_mem [256];
  logic [7:0]  addr_lat = 8'h00;
  logic [7:0]  wr_data  = 8'h00;
  logic        wr_pend  = 1'b0;
  logic [15:0] wlog [$];
  int          n_finint = 0;
  int          n_finwt  = 0;
  int          n_finct  = 0;
  int          viol     = 0;

  rtc_bus_sequencer #(
    .T_PHASE(4),
    .REG_CTL(8'h02),
    .REG_SEG(8'h21)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .iniciar (iniciar),
    .whileT  (whileT),
    .CrontUs (CrontUs),
    .usr_seg (usr_seg),
    .usr_min (usr_min),
    .usr_hora(usr_hora),
    .ad_in   (ad_in),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .AD_sel  (AD_sel),
    .CS_n    (CS_n),
    .RD_n    (RD_n),
    .WR_n    (WR_n),
    .finint  (finint),
    .finwt   (finwt),
    .finct   (finct),
    .seg     (seg),
    .min     (min),
    .hora    (hora),
    .busy    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ad_in = rtc_mem[addr_lat];

  // Chip model and bus monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RD_n === 1'b0 && WR_n === 1'b0) viol++;
    if (RD_n === 1'b0 && ad_oe === 1'b1) viol++;
    if (finint === 1'b1) n_finint++;
    if (finwt === 1'b1) n_finwt++;
    if (finct === 1'b1) n_finct++;
    if (CS_n === 1'b0 && AD_sel === 1'b0 && ad_oe === 1'b1) addr_lat = ad_out;
    if (CS_n === 1'b0 && AD_sel === 1'b1 && WR_n === 1'b0) begin
      wr_pend = 1'b1;
      wr_data = ad_out;
    end
    if (CS_n === 1'b1 && wr_pend) begin
      wlog.push_back({addr_lat, wr_data});
      rtc_mem[addr_lat] = wr_data;
      wr_pend = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int c);
    repeat (c) tick();
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return finint;
      1:       return finwt;
      default: return finct;
    endcase
  endfunction

  // Advance until the selected fin pulse; n counts cycles since the command cycle.
  task automatic wait_fin(input int sel, input int start, input int exp, input string tag);
    int n;
    n = start;
    while (pick(sel) !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
    rtc_mem[8'h21] = 8'h45;
    rtc_mem[8'h22] = 8'h30;
    rtc_mem[8'h23] = 8'h12;
    reset = 1'b0;
    iniciar = 1'b0;
    whileT = 1'b0;
    CrontUs = 1'b0;
    usr_seg = 8'h00;
    usr_min = 8'h00;
    usr_hora = 8'h00;
    tick_n(3);

    // Reset state
    check("rst_cs_n", CS_n, 1'b1);
    check("rst_rd_n", RD_n, 1'b1);
    check("rst_wr_n", WR_n, 1'b1);
    check("rst_ad_sel", AD_sel, 1'b0);
    check("rst_ad_oe", ad_oe, 1'b0);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_fins", {finint, finwt, finct}, 3'b000);
    check("rst_time", {seg, min, hora}, 24'h000000);
    reset = 1'b1;
    tick();

    // INIT: 02<-10, 02<-00, finint at k+33
    iniciar = 1'b1;
    tick();
    check("init_addr_cs", {CS_n, WR_n, RD_n, AD_sel, ad_oe}, 5'b00101);
    check("init_addr_val", ad_out, 8'h02);
    check("init_busy", busy, 1'b1);
    tick_n(4);
    check("init_gap1", {CS_n, WR_n, RD_n, AD_sel, ad_oe}, 5'b11100);
    tick_n(4);
    check("init_data", {CS_n, WR_n, RD_n, AD_sel, ad_oe}, 5'b00111);
    check("init_data_val", ad_out, 8'h10);
    wait_fin(0, 9, 33, "init_fin_cycle");
    check("init_busy_done", busy, 1'b1);
    tick();
    check("init_fin_low", finint, 1'b0);
    check("init_busy_low", busy, 1'b0);
    check("init_log_n", wlog.size(), 2);
    check("init_log0", wlog[0], 16'h0210);
    check("init_log1", wlog[1], 16'h0200);
    check("init_fin_count", n_finint, 1);
    iniciar = 1'b0;
    tick();

    // READ: 45/30/12 appear together at k+49
    whileT = 1'b1;
    tick();
    check("rd_addr", {CS_n, WR_n, RD_n, AD_sel, ad_oe}, 5'b00101);
    check("rd_addr_val", ad_out, 8'h21);
    tick_n(8);
    check("rd_data", {CS_n, WR_n, RD_n, AD_sel, ad_oe}, 5'b01010);
    tick_n(39);
    check("rd_prefin", finwt, 1'b0);
    check("rd_no_partial", {seg, min, hora}, 24'h000000);
    tick();
    check("rd_fin", finwt, 1'b1);
    check("rd_time", {seg, min, hora}, 24'h453012);
    check("rd_busy_done", busy, 1'b1);

    // Held level, then drop and re-rise at finwt+3
    tick();
    check("rd_idle_f1", {busy, finwt}, 2'b00);
    whileT = 1'b0;
    tick();
    check("rd_idle_f2", busy, 1'b0);
    tick();
    whileT = 1'b1;
    tick();
    check("rd2_start", {busy, CS_n}, 2'b10);
    check("rd2_addr", ad_out, 8'h21);
    wait_fin(1, 1, 49, "rd2_fin_cycle");
    tick_n(10);
    check("rd2_no_retrig", busy, 1'b0);
    check("rd_fin_count", n_finwt, 2);

    // WRITE with usr changed mid-sequence
    whileT = 1'b0;
    tick();
    CrontUs = 1'b1;
    usr_seg = 8'h59;
    usr_min = 8'h59;
    usr_hora = 8'h23;
    tick();
    check("wr_addr_val", ad_out, 8'h21);
    tick_n(4);
    usr_seg = 8'h00;
    usr_min = 8'h00;
    usr_hora = 8'h00;
    tick_n(4);
    check("wr_data", {CS_n, WR_n, RD_n, AD_sel, ad_oe}, 5'b00111);
    check("wr_data_val", ad_out, 8'h59);
    wait_fin(2, 9, 49, "wr_fin_cycle");
    check("wr_log_n", wlog.size(), 5);
    check("wr_log0", wlog[2], 16'h2159);
    check("wr_log1", wlog[3], 16'h2259);
    check("wr_log2", wlog[4], 16'h2323);
    check("wr_time_kept", {seg, min, hora}, 24'h453012);
    CrontUs = 1'b0;
    tick();

    // iniciar and whileT together: INIT only
    iniciar = 1'b1;
    whileT = 1'b1;
    tick();
    check("pri_addr", ad_out, 8'h02);
    wait_fin(0, 1, 33, "pri_fin_cycle");
    tick_n(10);
    check("pri_busy", busy, 1'b0);
    check("pri_finwt_count", n_finwt, 2);
    check("pri_finint_count", n_finint, 2);
    check("pri_log_n", wlog.size(), 7);
    iniciar = 1'b0;
    whileT = 1'b0;
    tick();

    // Reset in the middle of a READ
    whileT = 1'b1;
    tick();
    tick_n(20);
    check("mid_busy", busy, 1'b1);
    reset = 1'b0;
    whileT = 1'b0;
    tick_n(3);
    check("mid_strobes", {CS_n, RD_n, WR_n, ad_oe}, 4'b1110);
    check("mid_time", {seg, min, hora}, 24'h000000);
    check("mid_busy_rst", busy, 1'b0);
    reset = 1'b1;
    tick_n(60);
    check("mid_no_finwt", n_finwt, 2);
    check("mid_idle", busy, 1'b0);
    check("protocol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
